// File: rtl/spisdcard_cmd_sniffer_if.sv
// Decoded-transaction stream from the SD-card command sniffer.
// The sniffer drives the master side; a consumer pops entries through the slave side.
interface spisdcard_cmd_sniffer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_crc_ok;
    logic [7:0]  cmd_r1;
    logic        cmd_timeout;

    modport master (
        output cmd_valid, cmd_index, cmd_arg, cmd_crc_ok, cmd_r1, cmd_timeout,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, cmd_crc_ok, cmd_r1, cmd_timeout,
        output cmd_ready
    );
endinterface

// File: rtl/spisdcard_cmd_sniffer.sv
// Passive SPI-mode SD-card sniffer: frames 48-bit commands, checks CRC7, captures R1,
// and queues each transaction in a first-word-fall-through FIFO.
module spisdcard_cmd_sniffer #(
    parameter int SAMPLE_RISING = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int NCR_MAX       = 8,
    parameter int CHECK_CRC     = 1,
    parameter int CNT_W         = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   spisdcard_clk,
    input  logic                   spisdcard_cs_n,
    input  logic                   spisdcard_mosi,
    input  logic                   spisdcard_miso,
    spisdcard_cmd_sniffer_if.master cmd,
    output logic                   overflow,
    output logic [CNT_W-1:0]       frame_count,
    output logic [CNT_W-1:0]       abort_count
);
    localparam int   AW       = $clog2(FIFO_DEPTH);
    localparam logic CLK_IDLE = (SAMPLE_RISING != 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {IDLE, CMD, RESP, PUSH} state_t;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        logic        crc_ok;
        logic [7:0]  r1;
        logic        timeout;
    } entry_t;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    logic [1:0]       cs_sync_q, cs_sync_d, clk_sync_q, clk_sync_d;
    logic [1:0]       mosi_sync_q, mosi_sync_d, miso_sync_q, miso_sync_d;
    logic             clk_prev_q, clk_prev_d, strobe_q, strobe_d;
    logic             mosi_bit_q, mosi_bit_d, miso_bit_q, miso_bit_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       mosi_sh_q, mosi_sh_d, miso_sh_q, miso_sh_d;
    state_t           state_q, state_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       resp_cnt_q, resp_cnt_d;
    logic [5:0]       index_q, index_d;
    logic [31:0]      arg_q, arg_d;
    logic             crc_ok_q, crc_ok_d, timeout_q, timeout_d;
    logic [7:0]       r1_q, r1_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, abort_cnt_q, abort_cnt_d;
    entry_t           mem_q [FIFO_DEPTH];

    logic       cs_s, clk_s, edge_seen, byte_done, not_empty, full, pop, push_en;
    logic [7:0] mosi_byte, miso_byte;
    logic [6:0] crc_calc;
    entry_t     head, new_entry;

    assign cs_s      = cs_sync_q[1];
    assign clk_s     = clk_sync_q[1];
    assign edge_seen = (SAMPLE_RISING != 0) ? (clk_s & ~clk_prev_q) : (~clk_s & clk_prev_q);
    assign mosi_byte = {mosi_sh_q, mosi_bit_q};
    assign miso_byte = {miso_sh_q, miso_bit_q};
    // A strobe registered just before CS rose must not complete a byte.
    assign byte_done = strobe_q && !cs_s && (bit_cnt_q == 3'd7);
    assign crc_calc  = crc7({2'b01, index_q, arg_q});

    assign not_empty = (wr_ptr_q != rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = not_empty && cmd.cmd_ready;
    assign new_entry = '{index: index_q, arg: arg_q, crc_ok: crc_ok_q, r1: r1_q, timeout: timeout_q};
    assign head      = not_empty ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    assign cmd.cmd_valid   = not_empty;
    assign cmd.cmd_index   = head.index;
    assign cmd.cmd_arg     = head.arg;
    assign cmd.cmd_crc_ok  = head.crc_ok;
    assign cmd.cmd_r1      = head.r1;
    assign cmd.cmd_timeout = head.timeout;
    assign overflow        = overflow_q;
    assign frame_count     = frame_cnt_q;
    assign abort_count     = abort_cnt_q;

    always_comb begin
        cs_sync_d   = {cs_sync_q[0], spisdcard_cs_n};
        clk_sync_d  = {clk_sync_q[0], spisdcard_clk};
        mosi_sync_d = {mosi_sync_q[0], spisdcard_mosi};
        miso_sync_d = {miso_sync_q[0], spisdcard_miso};
        clk_prev_d  = clk_s;
        strobe_d    = edge_seen & ~cs_s;
        mosi_bit_d  = mosi_sync_q[1];
        miso_bit_d  = miso_sync_q[1];
        bit_cnt_d   = bit_cnt_q;
        mosi_sh_d   = mosi_sh_q;
        miso_sh_d   = miso_sh_q;
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        index_d     = index_q;
        arg_d       = arg_q;
        crc_ok_d    = crc_ok_q;
        r1_d        = r1_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;
        push_en     = 1'b0;

        if (cs_s) begin
            bit_cnt_d = 3'd0;
        end else if (strobe_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            mosi_sh_d = mosi_byte[6:0];
            miso_sh_d = miso_byte[6:0];
        end

        unique case (state_q)
            IDLE: begin
                if (byte_done && mosi_byte[7:6] == 2'b01) begin
                    index_d    = mosi_byte[5:0];
                    byte_cnt_d = 3'd1;
                    state_d    = CMD;
                end
            end
            CMD: begin
                if (cs_s) begin
                    abort_cnt_d = abort_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end else if (byte_done) begin
                    if (byte_cnt_q == 3'd5) begin
                        crc_ok_d   = (CHECK_CRC == 0) ||
                                     ((mosi_byte[7:1] == crc_calc) && mosi_byte[0]);
                        resp_cnt_d = 8'd0;
                        state_d    = RESP;
                    end else begin
                        arg_d      = {arg_q[23:0], mosi_byte};
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            RESP: begin
                if (cs_s) begin
                    abort_cnt_d = abort_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end else if (byte_done) begin
                    if (!miso_byte[7]) begin
                        r1_d      = miso_byte;
                        timeout_d = 1'b0;
                        state_d   = PUSH;
                    end else if (({1'b0, resp_cnt_q} + 9'd1) == 9'(NCR_MAX)) begin
                        r1_d      = 8'hFF;
                        timeout_d = 1'b1;
                        state_d   = PUSH;
                    end else begin
                        resp_cnt_d = resp_cnt_q + 8'd1;
                    end
                end
            end
            PUSH: begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                // A same-cycle pop frees the head slot, so a full FIFO still accepts.
                if (!full || pop) push_en = 1'b1;
                else              overflow_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cs_sync_q   <= 2'b11;
            clk_sync_q  <= {CLK_IDLE, CLK_IDLE};
            mosi_sync_q <= 2'b11;
            miso_sync_q <= 2'b11;
            clk_prev_q  <= CLK_IDLE;
            strobe_q    <= 1'b0;
            mosi_bit_q  <= 1'b1;
            miso_bit_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            mosi_sh_q   <= '0;
            miso_sh_q   <= '0;
            state_q     <= IDLE;
            byte_cnt_q  <= 3'd0;
            resp_cnt_q  <= 8'd0;
            index_q     <= '0;
            arg_q       <= '0;
            crc_ok_q    <= 1'b0;
            r1_q        <= 8'd0;
            timeout_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            clk_sync_q  <= clk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            miso_sync_q <= miso_sync_d;
            clk_prev_q  <= clk_prev_d;
            strobe_q    <= strobe_d;
            mosi_bit_q  <= mosi_bit_d;
            miso_bit_q  <= miso_bit_d;
            bit_cnt_q   <= bit_cnt_d;
            mosi_sh_q   <= mosi_sh_d;
            miso_sh_q   <= miso_sh_d;
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            crc_ok_q    <= crc_ok_d;
            r1_q        <= r1_d;
            timeout_q   <= timeout_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_en && !sys_rst) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
    end
endmodule

// File: tb/tb_spisdcard_cmd_sniffer.sv
// Directed bench: SPI frames drive two sniffers (mode 0 with CRC check, mode 1 without);
// expected entries are queued at issue time and checked by per-DUT monitors.
module tb_spisdcard_cmd_sniffer;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  s_clk, s_cs_n, s_mosi, s_miso;
    logic        a_ovf, b_ovf;
    logic [15:0] a_frames, a_aborts, b_frames, b_aborts;
    logic [47:0] got_a, got_b;
    logic [47:0] qa[$];
    logic [47:0] qb[$];
    int          total = 0;
    int          bad   = 0;

    localparam logic [47:0] CMD0     = 48'h40_00000000_95;
    localparam logic [47:0] CMD0_B94 = 48'h40_00000000_94;
    localparam logic [47:0] CMD0_B97 = 48'h40_00000000_97;
    localparam logic [47:0] CMD8     = 48'h48_000001AA_87;
    localparam logic [47:0] CMD17    = 48'h51_00000000_55;
    localparam logic [47:0] CMD55    = 48'h77_00000000_65;
    localparam logic [47:0] ACMD41   = 48'h69_40000000_77;

    spisdcard_cmd_sniffer_if a_if ();
    spisdcard_cmd_sniffer_if b_if ();

    always #5 sys_clk = ~sys_clk;

    spisdcard_cmd_sniffer #(.SAMPLE_RISING(1), .FIFO_DEPTH(4), .NCR_MAX(8), .CHECK_CRC(1), .CNT_W(16)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spisdcard_clk(s_clk[0]), .spisdcard_cs_n(s_cs_n[0]),
        .spisdcard_mosi(s_mosi[0]), .spisdcard_miso(s_miso[0]), .cmd(a_if.master),
        .overflow(a_ovf), .frame_count(a_frames), .abort_count(a_aborts));

    spisdcard_cmd_sniffer #(.SAMPLE_RISING(0), .FIFO_DEPTH(4), .NCR_MAX(8), .CHECK_CRC(0), .CNT_W(16)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spisdcard_clk(s_clk[1]), .spisdcard_cs_n(s_cs_n[1]),
        .spisdcard_mosi(s_mosi[1]), .spisdcard_miso(s_miso[1]), .cmd(b_if.master),
        .overflow(b_ovf), .frame_count(b_frames), .abort_count(b_aborts));

    assign got_a = {a_if.cmd_index, a_if.cmd_arg, a_if.cmd_crc_ok, a_if.cmd_r1, a_if.cmd_timeout};
    assign got_b = {b_if.cmd_index, b_if.cmd_arg, b_if.cmd_crc_ok, b_if.cmd_r1, b_if.cmd_timeout};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] ent(input logic [5:0] idx, input logic [31:0] arg,
                                        input logic crc, input logic [7:0] r1, input logic to);
        return {idx, arg, crc, r1, to};
    endfunction

    always @(negedge sys_clk) begin
        if (!sys_rst && a_if.cmd_valid && a_if.cmd_ready) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected: got %0h expected no entry", got_a);
            end else chk("a_entry", 64'(got_a), 64'(qa.pop_front()));
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst && b_if.cmd_valid && b_if.cmd_ready) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got %0h expected no entry", got_b);
            end else chk("b_entry", 64'(got_b), 64'(qb.pop_front()));
        end
    end

    task automatic wait_half();
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    // Mode 0 (sel 0): data set, then rising edge. Mode 1 (sel 1): data changes on rise, sampled on fall.
    task automatic spi_byte(input logic sel, input logic [7:0] mo, input logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            if (!sel) begin
                s_mosi[0] = mo[i]; s_miso[0] = mi[i];
                wait_half(); s_clk[0] = 1'b1;
                wait_half(); s_clk[0] = 1'b0;
            end else begin
                s_clk[1] = 1'b1; s_mosi[1] = mo[i]; s_miso[1] = mi[i];
                wait_half(); s_clk[1] = 1'b0;
                wait_half();
            end
        end
    endtask

    task automatic frame(input logic sel, input logic [47:0] c, input int ncmd,
                         input int nresp, input logic [63:0] resp);
        s_cs_n[sel] = 1'b0;
        wait_half();
        for (int k = 0; k < ncmd; k++) spi_byte(sel, c[47-8*k -: 8], 8'hFF);
        for (int k = 0; k < nresp; k++) spi_byte(sel, 8'hFF, resp[8*(nresp-1-k) +: 8]);
    endtask

    task automatic cs_up(input logic sel);
        wait_half();
        s_cs_n[sel] = 1'b1;
        repeat (8) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_drain(input logic sel);
        int n;
        n = 0;
        while (((!sel) ? qa.size() : qb.size()) != 0 && n < 3000) begin
            @(posedge sys_clk);
            n++;
        end
        chk(sel ? "b_drain_left" : "a_drain_left", 64'((!sel) ? qa.size() : qb.size()), 64'd0);
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        #1;
    endtask

    initial begin
        s_clk = 2'b00; s_cs_n = 2'b11; s_mosi = 2'b11; s_miso = 2'b11;
        a_if.cmd_ready = 1'b0;
        b_if.cmd_ready = 1'b1;
        do_reset();
        chk("rst_valid_a", 64'(a_if.cmd_valid), 64'd0);
        chk("rst_head_a", 64'(got_a), 64'd0);
        chk("rst_frames_a", 64'(a_frames), 64'd0);
        chk("rst_aborts_a", 64'(a_aborts), 64'd0);
        chk("rst_ovf_a", 64'(a_ovf), 64'd0);
        chk("rst_valid_b", 64'(b_if.cmd_valid), 64'd0);

        // CMD0, R1 on second response byte
        a_if.cmd_ready = 1'b1;
        qa.push_back(ent(6'd0, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(0, CMD0, 6, 2, 64'hFF01); cs_up(0);
        wait_drain(0);
        chk("frames_after_cmd0", 64'(a_frames), 64'd1);

        // CMD8 then CMD17 queued while consumer stalls
        a_if.cmd_ready = 1'b0;
        qa.push_back(ent(6'd8, 32'h000001AA, 1'b1, 8'h01, 1'b0));
        frame(0, CMD8, 6, 2, 64'hFF01); cs_up(0);
        qa.push_back(ent(6'd17, 32'h0, 1'b1, 8'h00, 1'b0));
        frame(0, CMD17, 6, 3, 64'hFFFF00); cs_up(0);
        chk("valid_while_stalled", 64'(a_if.cmd_valid), 64'd1);
        a_if.cmd_ready = 1'b1;
        wait_drain(0);
        chk("frames_after_cmd8_17", 64'(a_frames), 64'd3);

        // bad end bit, then bad CRC with good end bit
        qa.push_back(ent(6'd0, 32'h0, 1'b0, 8'h01, 1'b0));
        frame(0, CMD0_B94, 6, 2, 64'hFF01); cs_up(0);
        qa.push_back(ent(6'd0, 32'h0, 1'b0, 8'h01, 1'b0));
        frame(0, CMD0_B97, 6, 2, 64'hFF01); cs_up(0);
        wait_drain(0);

        // NCR timeout, then R1 on the last allowed byte
        qa.push_back(ent(6'd0, 32'h0, 1'b1, 8'hFF, 1'b1));
        frame(0, CMD0, 6, 8, 64'hFFFF_FFFF_FFFF_FFFF); cs_up(0);
        qa.push_back(ent(6'd0, 32'h0, 1'b1, 8'h00, 1'b0));
        frame(0, CMD0, 6, 8, 64'hFFFF_FFFF_FFFF_FF00); cs_up(0);
        wait_drain(0);
        chk("frames_after_timeout", 64'(a_frames), 64'd7);

        // five commands into a depth-4 FIFO: the fifth is dropped
        a_if.cmd_ready = 1'b0;
        qa.push_back(ent(6'd0, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(0, CMD0, 6, 2, 64'hFF01); cs_up(0);
        qa.push_back(ent(6'd8, 32'h000001AA, 1'b1, 8'h01, 1'b0));
        frame(0, CMD8, 6, 2, 64'hFF01); cs_up(0);
        qa.push_back(ent(6'd17, 32'h0, 1'b1, 8'h00, 1'b0));
        frame(0, CMD17, 6, 2, 64'hFF00); cs_up(0);
        qa.push_back(ent(6'd55, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(0, CMD55, 6, 2, 64'hFF01); cs_up(0);
        chk("ovf_before_fifth", 64'(a_ovf), 64'd0);
        frame(0, ACMD41, 6, 2, 64'hFF01); cs_up(0);
        chk("ovf_after_fifth", 64'(a_ovf), 64'd1);
        chk("frames_after_ovf", 64'(a_frames), 64'd12);
        a_if.cmd_ready = 1'b1;
        wait_drain(0);
        chk("valid_after_drain", 64'(a_if.cmd_valid), 64'd0);

        // abort after byte 3, then a clean CMD0
        frame(0, CMD17, 4, 0, 64'h0); cs_up(0);
        chk("aborts_a", 64'(a_aborts), 64'd1);
        qa.push_back(ent(6'd0, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(0, CMD0, 6, 2, 64'hFF01); cs_up(0);
        wait_drain(0);
        chk("frames_after_abort", 64'(a_frames), 64'd13);

        // mode 1, CRC check disabled: bad CRC byte still reports ok; abort behaves the same
        qb.push_back(ent(6'd0, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(1, CMD0_B94, 6, 2, 64'hFF01); cs_up(1);
        frame(1, CMD17, 4, 0, 64'h0); cs_up(1);
        chk("aborts_b", 64'(b_aborts), 64'd1);
        qb.push_back(ent(6'd0, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(1, CMD0, 6, 2, 64'hFF01); cs_up(1);
        wait_drain(1);
        chk("frames_b", 64'(b_frames), 64'd2);

        // full FIFO with a pop in the push cycle: nothing lost, no overflow
        do_reset();
        chk("rst2_ovf", 64'(a_ovf), 64'd0);
        chk("rst2_frames", 64'(a_frames), 64'd0);
        a_if.cmd_ready = 1'b0;
        qa.push_back(ent(6'd0, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(0, CMD0, 6, 2, 64'hFF01); cs_up(0);
        qa.push_back(ent(6'd8, 32'h000001AA, 1'b1, 8'h01, 1'b0));
        frame(0, CMD8, 6, 2, 64'hFF01); cs_up(0);
        qa.push_back(ent(6'd17, 32'h0, 1'b1, 8'h00, 1'b0));
        frame(0, CMD17, 6, 2, 64'hFF00); cs_up(0);
        qa.push_back(ent(6'd55, 32'h0, 1'b1, 8'h01, 1'b0));
        frame(0, CMD55, 6, 2, 64'hFF01); cs_up(0);
        qa.push_back(ent(6'd41, 32'h40000000, 1'b1, 8'h01, 1'b0));
        frame(0, ACMD41, 6, 2, 64'hFF01);
        // last R1 bit rose 4 cycles ago: the next edge is the push cycle
        a_if.cmd_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        a_if.cmd_ready = 1'b0;
        cs_up(0);
        chk("ovf_simul", 64'(a_ovf), 64'd0);
        chk("frames_simul", 64'(a_frames), 64'd5);
        chk("left_simul", 64'(qa.size()), 64'd4);
        a_if.cmd_ready = 1'b1;
        wait_drain(0);
        chk("valid_end", 64'(a_if.cmd_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spisdcard_cmd_sniffer.md
# spisdcard_cmd_sniffer

Synthesizable SPI-mode SD-card command sniffer clocked from the system clock. It oversamples the SD-card SPI pins, frames 48-bit commands, checks CRC7 and end bit, and captures the card's R1 response from MISO. Each decoded transaction goes into a parametrised FIFO behind a valid/ready handshake, with sticky error and statistics counters. It sits passively beside the SD-card SPI master, for on-chip debug and for scoreboard use in simulation.

## Interface
- SAMPLE_RISING, 1: 1 samples MOSI/MISO on rising `spisdcard_clk` (SPI mode 0); 0 samples on the falling edge.
- FIFO_DEPTH, 4: decoded-transaction FIFO entries; power of two, 2..64.
- NCR_MAX, 8: maximum response bytes clocked after the command before timeout; 1..255.
- CHECK_CRC, 1: 1 enables CRC7 checking; 0 forces `cmd_crc_ok`=1.
- CNT_W, 16: width of the statistics counters.
- sys_clk  in  1  system clock; must be at least 4× the `spisdcard_clk` frequency.
- sys_rst  in  1  synchronous, active-high reset.
- spisdcard_clk  in  1  SPI clock (asynchronous; synchronised internally).
- spisdcard_cs_n  in  1  chip select, active low.
- spisdcard_mosi  in  1  host-to-card data.
- spisdcard_miso  in  1  card-to-host data.
- cmd_valid  out  1  FIFO head entry valid.
- cmd_ready  in  1  consumer accepts the head entry.
- cmd_index  out  6  command index (byte0[5:0]).
- cmd_arg  out  32  argument (bytes 1..4, MSB first).
- cmd_crc_ok  out  1  CRC7 matched and end bit = 1.
- cmd_r1  out  8  R1 response byte; 0xFF on timeout.
- cmd_timeout  out  1  no R1 within NCR_MAX bytes.
- overflow  out  1  sticky; set when a completed entry is dropped because the FIFO is full.
- frame_count  out  CNT_W  completed transactions pushed or dropped; wraps.
- abort_count  out  CNT_W  frames cut short by CS deassert; wraps.

## Operation
- Pins pass through a 2-flop synchroniser, then a registered edge detector on the synchronised clock. A sample strobe fires on the selected edge while synchronised `cs_n`=0.
- Bit counter (3 bits) resets on `cs_n` high. Bytes are assembled MSB first, in parallel for MOSI and MISO. A byte completes on the 8th strobe.
- States:
  - IDLE: on a MOSI byte with [7:6]=01, store byte0 and go to CMD. Other bytes (0xFF fill) are ignored.
  - CMD: collect bytes 1..5. CRC7 (poly x^7+x^3+1, init 0) is computed bitwise over the 40 bits of bytes 0..4. `crc_ok` = (byte5[7:1]==crc) && byte5[0]. After byte 5, reset the response byte counter and go to RESP.
  - RESP: on each completed byte, if MISO byte[7]==0, capture it as R1 and go to PUSH. Otherwise increment the counter. When the counter reaches NCR_MAX, set timeout, set R1=0xFF, and go to PUSH.
  - PUSH: for one cycle, write {index, arg, crc_ok, r1, timeout} if the FIFO is not full; else set `overflow`. Increment `frame_count` either way. Return to IDLE.
- CS deassert in CMD or RESP increments `abort_count`, pushes nothing, and returns to IDLE. A partially received byte is discarded.
- FIFO is first-word fall-through. Pop occurs when `cmd_valid && cmd_ready`. A push and a pop in the same cycle while full are both accepted, and no overflow is raised.
- Data-phase bytes after R1 (read/write tokens) are not decoded. The block sits in IDLE and only a new 01-prefixed byte starts a frame.

## Timing
- Reset: state IDLE, FIFO empty, `cmd_valid`=0, all counters 0, `overflow`=0. The head fields read 0 while empty. Synchroniser flops reset to `cs_n`=1 and `clk`=SAMPLE_RISING^1, so no spurious edge follows reset.
- Pin-to-strobe latency: 3 `sys_clk` cycles (2 sync + 1 edge register).
- Final-R1-bit strobe → PUSH: 1 cycle. PUSH → `cmd_valid` high: 1 cycle. Total: 5 `sys_clk` cycles after the pin edge.
- `cmd_valid` and the head fields stay stable until accepted. `cmd_valid` deasserts the cycle after the last entry is popped.
- Counters update in the PUSH cycle, or in the cycle the CS-high strobe is seen. They wrap modulo 2^CNT_W.
- `sys_rst` mid-frame discards everything within one cycle.

## Test plan
- CMD0: bytes 40 00 00 00 00 95, card replies FF 01 → one entry: index 0, arg 0, crc_ok 1, r1 0x01, timeout 0, frame_count 1.
- CMD8 (48 00 00 01 AA 87, R1 0x01) followed by CMD17 (51 00 00 00 00 55, R1 0x00), with `cmd_ready`=0 → two entries, in order, with args 0x000001AA and 0x00000000.
- CMD0 with CRC byte 0x94 → crc_ok 0. The same frame with CHECK_CRC=0 → crc_ok 1. Also check an end bit of 0 (0x94) with CHECK_CRC=1 → crc_ok 0.
- NCR_MAX=8, MISO held at 0xFF for 8 bytes → r1 0xFF, timeout 1. An R1 arriving on byte 8 is accepted with timeout 0.
- FIFO_DEPTH=4, `cmd_ready`=0, 5 commands → 4 entries, overflow 1, frame_count 5. Then a simultaneous push/pop while full → no new overflow and the entry is stored.
- CS raised after byte 3 of a command, then a clean CMD0 → abort_count 1, exactly one entry (CMD0). Repeat with SAMPLE_RISING=0 in SPI mode 1 stimulus for identical results.
